// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

    localparam int DATA_W = 16;

    // MAR value that selects the switches (read) / hex display (write) instead of SRAM.
    localparam logic [DATA_W-1:0] IO_ADDR_SW_HEX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_DONE
    } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter with zero flag; times SRAM read and write strobes.
module mem_wait_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [2:0] r_count;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 3'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 3'd0)) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign o_zero = (r_count == 3'd0);

endmodule

// File: rtl/mem_responder.sv
// SLC-3 memory responder: services Mem_OE/Mem_WE against async SRAM or
// memory-mapped I/O. Every output comes straight from a register.
module mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int                ADDR_W    = 20,
    parameter int                RD_CYCLES = 1,
    parameter int                WR_CYCLES = 2,
    parameter logic [DATA_W-1:0] IO_ADDR   = IO_ADDR_SW_HEX
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       MAR,
    input  logic [15:0]       MDR_out,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       Switches,
    input  logic [15:0]       SRAM_DQ_in,
    output logic [15:0]       Data_to_CPU,
    output logic              Data_valid,
    output logic              Busy,
    output logic [15:0]       HEX_data,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [15:0]       SRAM_DQ_out,
    output logic              SRAM_DQ_oe
);

    // Counter terminates on zero, so load one less than the strobe length.
    localparam logic [2:0] RD_LOAD = 3'(RD_CYCLES - 1);
    localparam logic [2:0] WR_LOAD = 3'(WR_CYCLES - 1);

    generate
        if (RD_CYCLES < 1 || RD_CYCLES > 7) begin : g_bad_rd
            $error("mem_responder: RD_CYCLES must be in 1..7");
        end
        if (WR_CYCLES < 1 || WR_CYCLES > 7) begin : g_bad_wr
            $error("mem_responder: WR_CYCLES must be in 1..7");
        end
    endgenerate

    mem_state_t        r_state, w_state;
    logic              r_is_wr, w_is_wr;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [15:0]       r_dq_out, w_dq_out;
    logic              r_dq_oe, w_dq_oe;
    logic              r_ce_n, w_ce_n;
    logic              r_oe_n, w_oe_n;
    logic              r_we_n, w_we_n;
    logic              r_bl_n, w_bl_n;
    logic [15:0]       r_data, w_data;
    logic              r_valid, w_valid;
    logic [15:0]       r_hex, w_hex;
    logic              r_busy, w_busy;
    logic              w_req;
    logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [2:0]        w_cnt_val;

    mem_wait_counter u_wait (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and next-output logic; registered values hold unless changed.
    always_comb begin
        w_state    = r_state;
        w_is_wr    = r_is_wr;
        w_addr     = r_addr;
        w_dq_out   = r_dq_out;
        w_dq_oe    = r_dq_oe;
        w_ce_n     = r_ce_n;
        w_oe_n     = r_oe_n;
        w_we_n     = r_we_n;
        w_bl_n     = r_bl_n;
        w_data     = r_data;
        w_valid    = 1'b0;
        w_hex      = r_hex;
        w_cnt_load = 1'b0;
        w_cnt_val  = 3'd0;
        w_cnt_dec  = 1'b0;
        // The request that started the access decides when DONE releases.
        w_req      = r_is_wr ? Mem_WE : Mem_OE;

        case (r_state)
            ST_IDLE: begin
                if (Mem_WE || Mem_OE) begin
                    w_is_wr = Mem_WE;  // write wins a tie
                    if (MAR == IO_ADDR) begin
                        w_state = ST_DONE;
                        if (Mem_WE) begin
                            w_hex = MDR_out;
                        end else begin
                            w_data  = Switches;
                            w_valid = 1'b1;
                        end
                    end else if (Mem_WE) begin
                        w_state  = ST_WR_SETUP;
                        w_addr   = ADDR_W'(MAR);
                        w_dq_out = MDR_out;
                        w_dq_oe  = 1'b1;
                        w_ce_n   = 1'b0;
                        w_bl_n   = 1'b0;
                    end else begin
                        w_state    = ST_RD_ACT;
                        w_addr     = ADDR_W'(MAR);
                        w_ce_n     = 1'b0;
                        w_oe_n     = 1'b0;
                        w_bl_n     = 1'b0;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = RD_LOAD;
                    end
                end
            end
            ST_RD_ACT: begin
                if (!Mem_OE) begin
                    w_state = ST_IDLE;
                    w_ce_n  = 1'b1;
                    w_oe_n  = 1'b1;
                    w_bl_n  = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state = ST_DONE;
                    w_data  = SRAM_DQ_in;
                    w_valid = 1'b1;
                    w_ce_n  = 1'b1;
                    w_oe_n  = 1'b1;
                    w_bl_n  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_WR_SETUP: begin
                if (!Mem_WE) begin
                    w_state = ST_IDLE;
                    w_ce_n  = 1'b1;
                    w_bl_n  = 1'b1;
                    w_dq_oe = 1'b0;
                end else begin
                    w_state    = ST_WR_PULSE;
                    w_we_n     = 1'b0;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = WR_LOAD;
                end
            end
            ST_WR_PULSE: begin
                // A started pulse always runs to full length.
                if (w_cnt_zero) begin
                    w_state = ST_DONE;
                    w_we_n  = 1'b1;
                    w_ce_n  = 1'b1;
                    w_bl_n  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                // DQ stays driven for the first DONE cycle as data hold.
                w_dq_oe = 1'b0;
                if (!w_req) begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_is_wr  <= 1'b0;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_bl_n   <= 1'b1;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_hex    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_is_wr  <= w_is_wr;
            r_addr   <= w_addr;
            r_dq_out <= w_dq_out;
            r_dq_oe  <= w_dq_oe;
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_bl_n   <= w_bl_n;
            r_data   <= w_data;
            r_valid  <= w_valid;
            r_hex    <= w_hex;
            r_busy   <= w_busy;
        end
    end

    assign Data_to_CPU = r_data;
    assign Data_valid  = r_valid;
    assign Busy        = r_busy;
    assign HEX_data    = r_hex;
    assign SRAM_ADDR   = r_addr;
    assign SRAM_CE_N   = r_ce_n;
    assign SRAM_UB_N   = r_bl_n;
    assign SRAM_LB_N   = r_bl_n;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_DQ_out = r_dq_out;
    assign SRAM_DQ_oe  = r_dq_oe;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default-timing instance plus an RD_CYCLES=3 instance.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] MAR = '0, MDR_out = '0, Switches = '0;
    logic        Mem_OE = 1'b0, Mem_WE = 1'b0;
    logic        Mem_OE3 = 1'b0, Mem_WE3 = 1'b0;
    logic        preload = 1'b1;

    logic [15:0] Data_to_CPU, HEX_data, SRAM_DQ_out, SRAM_DQ_in;
    logic        Data_valid, Busy, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe;
    logic [19:0] SRAM_ADDR;

    logic [15:0] Data_to_CPU3, HEX_data3, SRAM_DQ_out3, SRAM_DQ_in3;
    logic        Data_valid3, Busy3, SRAM_CE_N3, SRAM_UB_N3, SRAM_LB_N3, SRAM_OE_N3, SRAM_WE_N3, SRAM_DQ_oe3;
    logic [19:0] SRAM_ADDR3;

    int total = 0;
    int bad = 0;
    int ce_cnt = 0, oe_cnt = 0, we_cnt = 0, vld_cnt = 0, vld_cnt3 = 0;
    int c0, c1, c2;

    logic [15:0] mem [0:65535];

    always #5 Clk = ~Clk;

    mem_responder u_dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR_out(MDR_out),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in),
        .Data_to_CPU(Data_to_CPU), .Data_valid(Data_valid), .Busy(Busy), .HEX_data(HEX_data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe)
    );

    mem_responder #(.RD_CYCLES(3)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR_out(MDR_out),
        .Mem_OE(Mem_OE3), .Mem_WE(Mem_WE3), .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in3),
        .Data_to_CPU(Data_to_CPU3), .Data_valid(Data_valid3), .Busy(Busy3), .HEX_data(HEX_data3),
        .SRAM_ADDR(SRAM_ADDR3), .SRAM_CE_N(SRAM_CE_N3), .SRAM_UB_N(SRAM_UB_N3), .SRAM_LB_N(SRAM_LB_N3),
        .SRAM_OE_N(SRAM_OE_N3), .SRAM_WE_N(SRAM_WE_N3), .SRAM_DQ_out(SRAM_DQ_out3), .SRAM_DQ_oe(SRAM_DQ_oe3)
    );

    // SRAM model: drives data only while chip and output enable are low.
    assign SRAM_DQ_in  = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[15:0]] : 16'h0000;
    assign SRAM_DQ_in3 = (!SRAM_CE_N3 && !SRAM_OE_N3) ? mem[SRAM_ADDR3[15:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (preload)
            mem[16'h0042] <= 16'hBEEF;
        else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe)
            mem[SRAM_ADDR[15:0]] <= SRAM_DQ_out;
    end

    // Activity counters sampled mid-cycle.
    always @(negedge Clk) begin
        if (!SRAM_CE_N) ce_cnt <= ce_cnt + 1;
        if (!SRAM_OE_N) oe_cnt <= oe_cnt + 1;
        if (!SRAM_WE_N) we_cnt <= we_cnt + 1;
        if (Data_valid) vld_cnt <= vld_cnt + 1;
        if (Data_valid3) vld_cnt3 <= vld_cnt3 + 1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ce", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rst_oe", SRAM_DQ_oe, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", Data_valid, 0);
        chk("rst_data", Data_to_CPU, 0);
        chk("rst_hex", HEX_data, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dq", SRAM_DQ_out, 0);
        Reset = 1'b0; preload = 1'b0;
        tick();

        // SRAM read x0042
        c0 = oe_cnt; c1 = ce_cnt;
        MAR = 16'h0042; Mem_OE = 1'b1;          // cycle n
        tick();                                  // n+1
        chk("rd_oe_low", {SRAM_CE_N, SRAM_OE_N, SRAM_LB_N}, 0);
        chk("rd_addr", SRAM_ADDR, 32'h00042);
        chk("rd_busy", Busy, 1);
        chk("rd_novalid", Data_valid, 0);
        tick();                                  // n+2
        chk("rd_valid", Data_valid, 1);
        chk("rd_data", Data_to_CPU, 16'hBEEF);
        chk("rd_oe_high", {SRAM_CE_N, SRAM_OE_N}, 2'b11);
        Mem_OE = 1'b0;
        tick();
        chk("rd_idle", Busy, 0);
        chk("rd_pulse", Data_valid, 0);
        chk("rd_oe_cnt", oe_cnt - c0, 1);
        chk("rd_ce_cnt", ce_cnt - c1, 1);

        // SRAM write x1234 <= xA5A5
        c0 = we_cnt;
        MAR = 16'h1234; MDR_out = 16'hA5A5; Mem_WE = 1'b1;   // n
        tick();                                               // n+1
        chk("wr_setup", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_oe}, 3'b011);
        chk("wr_addr", SRAM_ADDR, 32'h01234);
        chk("wr_dq", SRAM_DQ_out, 16'hA5A5);
        tick();                                               // n+2
        chk("wr_we_n2", {SRAM_WE_N, SRAM_DQ_oe}, 2'b01);
        tick();                                               // n+3
        chk("wr_we_n3", {SRAM_WE_N, SRAM_DQ_oe}, 2'b01);
        Mem_WE = 1'b0;
        tick();                                               // n+4
        chk("wr_hold", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_oe, Busy}, 4'b1111);
        tick();                                               // n+5
        chk("wr_release", {SRAM_DQ_oe, Busy}, 2'b00);
        chk("wr_we_cnt", we_cnt - c0, 2);
        chk("wr_mem", mem[16'h1234], 16'hA5A5);

        // I/O read and write
        c0 = ce_cnt; c1 = we_cnt;
        Switches = 16'h00FF; MAR = 16'hFFFF; Mem_OE = 1'b1;
        tick();
        chk("io_rd_valid", Data_valid, 1);
        chk("io_rd_data", Data_to_CPU, 16'h00FF);
        chk("io_rd_ce", SRAM_CE_N, 1);
        Mem_OE = 1'b0;
        tick();
        chk("io_rd_idle", {Busy, Data_valid}, 0);
        MDR_out = 16'h1357; Mem_WE = 1'b1;
        tick();
        chk("io_wr_hex", HEX_data, 16'h1357);
        Mem_WE = 1'b0;
        tick();
        chk("io_wr_idle", Busy, 0);
        chk("io_no_sram", {ce_cnt - c0, we_cnt - c1}, 0);

        // Both requests: write wins, no read data
        c0 = vld_cnt; c1 = we_cnt;
        MAR = 16'h0010; MDR_out = 16'h5A5A; Mem_OE = 1'b1; Mem_WE = 1'b1;
        tick();
        chk("both_setup", {SRAM_OE_N, SRAM_DQ_oe, SRAM_CE_N}, 3'b110);
        tick(); tick(); tick();                  // n+4: DONE
        chk("both_done", {SRAM_WE_N, Busy}, 2'b11);
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        tick();
        chk("both_idle", Busy, 0);
        chk("both_novalid", vld_cnt - c0, 0);
        chk("both_we_cnt", we_cnt - c1, 2);
        chk("both_mem", mem[16'h0010], 16'h5A5A);

        // Write dropped in WR_SETUP: no pulse
        c0 = we_cnt;
        MAR = 16'h0011; MDR_out = 16'h4444; Mem_WE = 1'b1;
        tick();
        Mem_WE = 1'b0;
        tick();
        chk("wsetup_abort", {Busy, SRAM_CE_N, SRAM_DQ_oe}, 3'b010);
        chk("wsetup_nowe", we_cnt - c0, 0);

        // Write dropped in WR_PULSE: full pulse anyway
        c0 = we_cnt;
        MAR = 16'h0020; MDR_out = 16'h0F0F; Mem_WE = 1'b1;
        tick(); tick();                          // n+2: pulse started
        Mem_WE = 1'b0;
        tick();                                  // n+3
        chk("wpulse_hold", {SRAM_WE_N, Busy}, 2'b01);
        tick();                                  // n+4 DONE
        chk("wpulse_done", {SRAM_WE_N, SRAM_DQ_oe}, 2'b11);
        tick();
        chk("wpulse_idle", Busy, 0);
        chk("wpulse_cnt", we_cnt - c0, 2);
        chk("wpulse_mem", mem[16'h0020], 16'h0F0F);

        // Reset during WR_PULSE
        MAR = 16'h0030; MDR_out = 16'h7777; Mem_WE = 1'b1;
        tick(); tick();
        chk("rstw_pulse", SRAM_WE_N, 0);
        Reset = 1'b1;
        tick();
        chk("rstw_pins", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rstw_oe_busy", {SRAM_DQ_oe, Busy}, 0);
        chk("rstw_hex", HEX_data, 0);
        Reset = 1'b0; Mem_WE = 1'b0;
        tick();
        MAR = 16'h0042; Mem_OE = 1'b1;
        tick();
        chk("rstr_oe", SRAM_OE_N, 0);
        tick();
        chk("rstr_data", {Data_valid, Data_to_CPU}, {1'b1, 16'hBEEF});
        Mem_OE = 1'b0;
        tick();

        // RD_CYCLES=3 instance: full read then an early drop
        MAR = 16'h0042; Mem_OE3 = 1'b1;          // n
        tick();                                  // n+1
        chk("r3_oe1", {SRAM_OE_N3, Data_valid3}, 0);
        tick();                                  // n+2
        chk("r3_oe2", {SRAM_OE_N3, Data_valid3}, 0);
        tick();                                  // n+3
        chk("r3_oe3", {SRAM_OE_N3, Data_valid3}, 0);
        tick();                                  // n+4
        chk("r3_valid", {Data_valid3, SRAM_OE_N3, Data_to_CPU3}, {2'b11, 16'hBEEF});
        Mem_OE3 = 1'b0;
        tick();
        chk("r3_idle", Busy3, 0);
        c2 = vld_cnt3;
        MAR = 16'h0010; Mem_OE3 = 1'b1;          // n
        tick();                                  // n+1
        Mem_OE3 = 1'b0;
        tick();                                  // n+2
        chk("r3_abort", {Busy3, SRAM_OE_N3, SRAM_CE_N3}, 3'b011);
        tick(); tick();
        chk("r3_keep", Data_to_CPU3, 16'hBEEF);
        chk("r3_novalid", vld_cnt3 - c2, 0);
        chk("r3_quiet", {HEX_data3, SRAM_DQ_out3, SRAM_DQ_oe3, SRAM_WE_N3, SRAM_UB_N3, SRAM_LB_N3},
            {16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
